// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file host controller: default
// geometry that must agree with the register file, and FSM state encodings.
package regfile_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int DEPTH_DEF = 8;
    localparam int ADDR_DEF  = 3;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WR       = 3'd1;
    localparam logic [2:0] S_RD_ISSUE = 3'd2;
    localparam logic [2:0] S_RD_WAIT  = 3'd3;
    localparam logic [2:0] S_RSP      = 3'd4;

    typedef enum logic [2:0] {
        IDLE     = S_IDLE,
        WR       = S_WR,
        RD_ISSUE = S_RD_ISSUE,
        RD_WAIT  = S_RD_WAIT,
        RSP      = S_RSP
    } ctrlState;

endpackage

// File: rtl/rf_addr_gen.sv
// Register-file address counter: loads a start address or steps by one,
// wrapping from DEPTH-1 back to 0 even when DEPTH is not a power of two.
// nextAddr is the value the counter takes at the coming edge.
module rf_addr_gen
    import regfile_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int ADDR  = ADDR_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [ADDR-1:0] loadAddr,
    input  logic            inc,
    output logic [ADDR-1:0] nextAddr
);

    localparam logic [ADDR-1:0] LAST = ADDR'(DEPTH - 1);

    logic [ADDR-1:0] addr;

    // Load has priority over increment; increment wraps at the last entry.
    always_comb begin
        nextAddr = addr;
        if (load) begin
            nextAddr = loadAddr;
        end else if (inc) begin
            nextAddr = (addr == LAST) ? '0 : addr + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr <= '0;
        end else begin
            addr <= nextAddr;
        end
    end

endmodule

// File: rtl/regfile_host_ctrl.sv
// Initiator-side controller for a register file WrEn/RdEn port. Accepts
// single writes and read bursts on a valid/ready command channel and
// returns read data on a valid/ready response channel. All outputs are
// registered from the next-state decode.
// Optional build macro REGFILE_HOST_WR_VERIFY_EN: every write is read back
// from the same address and compared; a mismatch pulses Wr_Err for one cycle.
module regfile_host_ctrl
    import regfile_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR   = ADDR_DEF,
    parameter int LEN_W  = 3,
    parameter int RD_LAT = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Cmd_Valid,
    output logic             Cmd_Ready,
    input  logic             Cmd_Wr,
    input  logic [ADDR-1:0]  Cmd_Addr,
    input  logic [WIDTH-1:0] Cmd_WrData,
    input  logic [LEN_W-1:0] Cmd_Len,
    output logic             Rsp_Valid,
    input  logic             Rsp_Ready,
    output logic [WIDTH-1:0] Rsp_Data,
    output logic             Rsp_Last,
    output logic             WrEn,
    output logic             RdEn,
    output logic [ADDR-1:0]  Address,
    output logic [WIDTH-1:0] WrData,
    input  logic [WIDTH-1:0] RdData,
    output logic             Busy,
    output logic             Wr_Err
);

    localparam int WAIT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    ctrlState          state;
    ctrlState          stateNext;
    logic              accept;
    logic              agInc;
    logic              waitDone;
    logic [ADDR-1:0]   agNext;
    logic [LEN_W-1:0]  remCnt;
    logic [WAIT_W-1:0] waitCnt;
    logic              verifyFlag;

    rf_addr_gen #(
        .DEPTH (DEPTH),
        .ADDR  (ADDR)
    ) u_addrGen (
        .clk      (CLK),
        .rst      (RST),
        .load     (accept),
        .loadAddr (Cmd_Addr),
        .inc      (agInc),
        .nextAddr (agNext)
    );

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state decode and single-cycle control pulses.
    always_comb begin
        stateNext = state;
        accept    = 1'b0;
        agInc     = 1'b0;
        waitDone  = 1'b0;
        case (state)
            IDLE: begin
                if (Cmd_Valid && Cmd_Ready) begin
                    accept    = 1'b1;
                    stateNext = Cmd_Wr ? WR : RD_ISSUE;
                end
            end
            WR: begin
`ifdef REGFILE_HOST_WR_VERIFY_EN
                stateNext = RD_ISSUE;
`else
                stateNext = IDLE;
`endif
            end
            RD_ISSUE: begin
                stateNext = RD_WAIT;
            end
            RD_WAIT: begin
                if (waitCnt == '0) begin
                    waitDone  = 1'b1;
                    stateNext = verifyFlag ? IDLE : RSP;
                end
            end
            RSP: begin
                if (Rsp_Valid && Rsp_Ready) begin
                    if (remCnt == '0) begin
                        stateNext = IDLE;
                    end else begin
                        agInc     = 1'b1;
                        stateNext = RD_ISSUE;
                    end
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Remaining-beat and read-latency counters.
    always_ff @(posedge CLK) begin
        if (RST) begin
            remCnt  <= '0;
            waitCnt <= '0;
        end else begin
            if (accept) begin
                remCnt <= Cmd_Len;
            end else if (agInc) begin
                remCnt <= remCnt - 1'b1;
            end
            if (state == RD_ISSUE) begin
                waitCnt <= WAIT_W'(RD_LAT - 1);
            end else if (state == RD_WAIT && waitCnt != '0) begin
                waitCnt <= waitCnt - 1'b1;
            end
        end
    end

    // Registered outputs decoded from the state being entered.
    always_ff @(posedge CLK) begin
        if (RST) begin
            Cmd_Ready <= 1'b1;
            WrEn      <= 1'b0;
            RdEn      <= 1'b0;
            Rsp_Valid <= 1'b0;
            Rsp_Last  <= 1'b0;
            Busy      <= 1'b0;
            Address   <= '0;
            WrData    <= '0;
            Rsp_Data  <= '0;
        end else begin
            Cmd_Ready <= (stateNext == IDLE);
            WrEn      <= (stateNext == WR);
            RdEn      <= (stateNext == RD_ISSUE);
            Rsp_Valid <= (stateNext == RSP);
            Rsp_Last  <= (stateNext == RSP) && (remCnt == '0);
            Busy      <= (stateNext != IDLE);
            if (stateNext == WR || stateNext == RD_ISSUE) begin
                Address <= agNext;
            end
            if (accept && Cmd_Wr) begin
                WrData <= Cmd_WrData;
            end
            if (waitDone && !verifyFlag) begin
                Rsp_Data <= RdData;
            end
        end
    end

`ifdef REGFILE_HOST_WR_VERIFY_EN
    // Verify flag marks a read-back of a write; WrData still holds the value written.
    always_ff @(posedge CLK) begin
        if (RST) begin
            verifyFlag <= 1'b0;
            Wr_Err     <= 1'b0;
        end else begin
            if (accept) begin
                verifyFlag <= Cmd_Wr;
            end
            Wr_Err <= waitDone && verifyFlag && (RdData != WrData);
        end
    end
`else
    assign verifyFlag = 1'b0;
    assign Wr_Err     = 1'b0;
`endif

endmodule
